// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared encodings for the load/store unit. This package holds
//                the mem_op codes, the FSM state codes and the request
//                legality check. The control decoder uses the same encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    // mem_op encodings. Bit 2 selects zero-extension and bits [1:0] give the size.
    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    // FSM state encodings
    localparam int unsigned STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_REQ  = 2'd1;
    localparam logic [STATE_W-1:0] ST_WAIT = 2'd2;
    localparam logic [STATE_W-1:0] ST_RESP = 2'd3;

    // A request is legal when its op is valid for its direction and its
    // address is naturally aligned for the access size. Unsigned ops exist
    // only for loads.
    function automatic logic is_legal(input logic       we,
                                      input logic [2:0] op,
                                      input logic [1:0] lo);
        logic ok;
        case (op)
            MEM_B:   ok = 1'b1;
            MEM_H:   ok = ~lo[0];
            MEM_W:   ok = (lo == 2'b00);
            MEM_BU:  ok = ~we;
            MEM_HU:  ok = ~we & ~lo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Combinational lane logic for the LSU. It generates the byte
//                strobes, replicates store data across the lanes, and shifts
//                and extends load data.
//  Ports       : op, addr_lo        - access size/sign and byte offset
//                store_data         - right-aligned store data
//                load_data          - raw 32-bit bus read data
//                wstrb, lane_data   - byte strobes and lane-placed store data
//                load_ext           - right-aligned, extended load result
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_data,
    output logic [3:0]  wstrb,
    output logic [31:0] lane_data,
    output logic [31:0] load_ext
);

    logic [31:0] w_shifted;

    // Replicating store data means any lane the strobe picks already holds
    // the right bytes, so no data shifter is needed.
    always_comb begin
        wstrb     = 4'b1111;
        lane_data = store_data;
        case (op[1:0])
            2'b00: begin
                wstrb     = 4'b0001 << addr_lo;
                lane_data = {4{store_data[7:0]}};
            end
            2'b01: begin
                wstrb     = 4'b0011 << addr_lo;
                lane_data = {2{store_data[15:0]}};
            end
            default: begin
                wstrb     = 4'b1111;
                lane_data = store_data;
            end
        endcase
    end

    assign w_shifted = load_data >> {addr_lo, 3'b000};

    always_comb begin
        load_ext = w_shifted;
        case (op)
            MEM_B:   load_ext = {{24{w_shifted[7]}},  w_shifted[7:0]};
            MEM_H:   load_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
            MEM_BU:  load_ext = {24'd0, w_shifted[7:0]};
            MEM_HU:  load_ext = {16'd0, w_shifted[15:0]};
            default: load_ext = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
//  Module      : lsu
//  Description : Load/store unit. It takes one core request at a time, checks
//                that the request is legal, and runs a single bus transaction
//                for it. It returns a one-cycle response with extended load
//                data or an error. A response that never arrives is reported
//                as an error after TIMEOUT_CYCLES cycles in WAIT.
//  Ports       : clk, rst_n               - clock, async active-low reset
//                req_* / mem_* / addr / wdata - core request
//                rsp_*                    - core response (registered)
//                bus_req_* / bus_we/addr/wdata/wstrb - bus request (registered)
//                bus_rsp_valid/rdata/err  - bus response
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_write,
    input  logic [2:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_rsp_err
);

    // The counter only has to reach TIMEOUT_CYCLES-1. The timeout fires on
    // that WAIT cycle.
    localparam int unsigned c_TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);

    logic [STATE_W-1:0] r_state;
    logic [c_TMO_W-1:0] r_tmo;
    logic [2:0]         r_op;
    logic [1:0]         r_addr_lo;
    logic               r_we;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_rdata;
    logic               r_rsp_err;
    logic               r_bus_req_valid;
    logic               r_bus_we;
    logic [31:0]        r_bus_addr;
    logic [31:0]        r_bus_wdata;
    logic [3:0]         r_bus_wstrb;

    logic [2:0]         w_op;
    logic [1:0]         w_addr_lo;
    logic [3:0]         w_wstrb;
    logic [31:0]        w_lane_data;
    logic [31:0]        w_load_ext;

    // One aligner serves both ends of a transaction. In IDLE it sees the
    // incoming request, which is used for store lane placement. Otherwise it
    // sees the captured request, which is used for load extraction in WAIT.
    assign w_op      = (r_state == ST_IDLE) ? mem_op    : r_op;
    assign w_addr_lo = (r_state == ST_IDLE) ? addr[1:0] : r_addr_lo;

    lsu_align u_align (
        .op         (w_op),
        .addr_lo    (w_addr_lo),
        .store_data (wdata),
        .load_data  (bus_rdata),
        .wstrb      (w_wstrb),
        .lane_data  (w_lane_data),
        .load_ext   (w_load_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_tmo           <= '0;
            r_op            <= 3'b000;
            r_addr_lo       <= 2'b00;
            r_we            <= 1'b0;
            r_req_ready     <= 1'b0;
            r_rsp_valid     <= 1'b0;
            r_rsp_rdata     <= 32'd0;
            r_rsp_err       <= 1'b0;
            r_bus_req_valid <= 1'b0;
            r_bus_we        <= 1'b0;
            r_bus_addr      <= 32'd0;
            r_bus_wdata     <= 32'd0;
            r_bus_wstrb     <= 4'b0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_op        <= mem_op;
                        r_addr_lo   <= addr[1:0];
                        r_we        <= mem_write;
                        if (is_legal(mem_write, mem_op, addr[1:0])) begin
                            r_state         <= ST_REQ;
                            r_bus_req_valid <= 1'b1;
                            r_bus_we        <= mem_write;
                            r_bus_addr      <= {addr[31:2], 2'b00};
                            r_bus_wdata     <= mem_write ? w_lane_data : 32'd0;
                            r_bus_wstrb     <= mem_write ? w_wstrb : 4'b0000;
                        end else begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= 32'd0;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus_req_ready) begin
                        r_state         <= ST_WAIT;
                        r_tmo           <= '0;
                        r_bus_req_valid <= 1'b0;
                        r_bus_we        <= 1'b0;
                        r_bus_addr      <= 32'd0;
                        r_bus_wdata     <= 32'd0;
                        r_bus_wstrb     <= 4'b0000;
                    end
                end
                ST_WAIT: begin
                    if (bus_rsp_valid) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= bus_rsp_err;
                        r_rsp_rdata <= (bus_rsp_err || r_we) ? 32'd0 : w_load_ext;
                    end else if (r_tmo == c_TMO_LAST) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_rdata <= 32'd0;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state     <= ST_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= 32'd0;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready     = r_req_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_err       = r_rsp_err;
    assign bus_req_valid = r_bus_req_valid;
    assign bus_we        = r_bus_we;
    assign bus_addr      = r_bus_addr;
    assign bus_wdata     = r_bus_wdata;
    assign bus_wstrb     = r_bus_wstrb;

endmodule
`default_nettype wire
